// File: rtl/updown_counter.sv
// Parametrised up/down counter: programmable step and terminal value,
// wrap or saturate at the ends, with registered overflow/underflow flags.
module updown_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             overflow,
  output logic             underflow,
  output logic             at_max,
  output logic             at_zero
);

  localparam int unsigned EW = WIDTH + 1;

  localparam logic [EW-1:0] MAX_EXT = {1'b0, MAX_VALUE};
  localparam logic [EW-1:0] MODULUS = MAX_EXT + EW'(1);

  logic [WIDTH-1:0] step_clamped;
  logic [EW-1:0]    step_ext;
  logic [EW-1:0]    value_ext;
  logic [EW-1:0]    sum_up;
  logic [EW-1:0]    wrap_up;
  logic [EW-1:0]    wrap_down;
  logic             past_max;
  logic             below_zero;

  logic [WIDTH-1:0] value_nxt;
  logic             overflow_nxt;
  logic             underflow_nxt;

  // Candidate results for both directions, kept one bit wider than the count
  always_comb begin
    step_clamped = (step > MAX_VALUE) ? MAX_VALUE : step;
    step_ext     = {1'b0, step_clamped};
    value_ext    = {1'b0, value};
    sum_up       = value_ext + step_ext;
    past_max     = (sum_up > MAX_EXT);
    below_zero   = (value_ext < step_ext);
    wrap_up      = sum_up - MODULUS;
    wrap_down    = value_ext + MODULUS - step_ext;
  end

  // Next-state selection in priority order: clear, load, count, hold
  always_comb begin
    value_nxt     = value;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    if (clear) begin
      value_nxt     = '0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else if (load) begin
      value_nxt     = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else if (enable) begin
      if (up) begin
        underflow_nxt = 1'b0;
        overflow_nxt  = past_max;
        if (!past_max) begin
          value_nxt = sum_up[WIDTH-1:0];
        end else if (SATURATE) begin
          value_nxt = MAX_VALUE;
        end else begin
          value_nxt = wrap_up[WIDTH-1:0];
        end
      end else begin
        overflow_nxt  = 1'b0;
        underflow_nxt = below_zero;
        if (!below_zero) begin
          value_nxt = value - step_clamped;
        end else if (SATURATE) begin
          value_nxt = '0;
        end else begin
          value_nxt = wrap_down[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      value     <= value_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  assign at_max  = (value == MAX_VALUE);
  assign at_zero = (value == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: four parameterisations share one stimulus stream
// and are checked every cycle against an integer reference model.
module tb_updown_counter;

  localparam int N = 4;
  localparam int MXS  [N] = '{255, 9, 200, 100};
  localparam bit SATS [N] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       reset_n, enable, up, load, clear;
  logic [7:0] step, load_value;

  logic [7:0] val   [N];
  logic       ovf   [N];
  logic       unf   [N];
  logic       amax  [N];
  logic       azero [N];

  int total = 0;
  int bad   = 0;

  // Model state per instance: {overflow, underflow, value}
  logic [9:0] mst [N];
  bit         model_on = 1'b0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(8), .MAX_VALUE(8'd255), .SATURATE(1'b0)) d0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .step(step),
    .load(load), .load_value(load_value), .clear(clear), .value(val[0]),
    .overflow(ovf[0]), .underflow(unf[0]), .at_max(amax[0]), .at_zero(azero[0]));
  updown_counter #(.WIDTH(8), .MAX_VALUE(8'd9), .SATURATE(1'b0)) d1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .step(step),
    .load(load), .load_value(load_value), .clear(clear), .value(val[1]),
    .overflow(ovf[1]), .underflow(unf[1]), .at_max(amax[1]), .at_zero(azero[1]));
  updown_counter #(.WIDTH(8), .MAX_VALUE(8'd200), .SATURATE(1'b1)) d2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .step(step),
    .load(load), .load_value(load_value), .clear(clear), .value(val[2]),
    .overflow(ovf[2]), .underflow(unf[2]), .at_max(amax[2]), .at_zero(azero[2]));
  updown_counter #(.WIDTH(8), .MAX_VALUE(8'd100), .SATURATE(1'b0)) d3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .step(step),
    .load(load), .load_value(load_value), .clear(clear), .value(val[3]),
    .overflow(ovf[3]), .underflow(unf[3]), .at_max(amax[3]), .at_zero(azero[3]));

  // Reference behaviour in plain integer arithmetic
  function automatic logic [9:0] model_next(input int idx, input logic [9:0] cur);
    int mx, v, s, t;
    bit o, u;
    mx = MXS[idx];
    v  = int'(cur[7:0]);
    o  = cur[9];
    u  = cur[8];
    if (!reset_n || clear) begin
      v = 0; o = 0; u = 0;
    end else if (load) begin
      v = (int'(load_value) > mx) ? mx : int'(load_value);
      o = 0; u = 0;
    end else if (enable) begin
      s = (int'(step) > mx) ? mx : int'(step);
      if (up) begin
        t = v + s;
        u = 0;
        o = (t > mx);
        if (t <= mx)      v = t;
        else if (SATS[idx]) v = mx;
        else              v = t - (mx + 1);
      end else begin
        o = 0;
        u = (v < s);
        if (v >= s)       v = v - s;
        else if (SATS[idx]) v = 0;
        else              v = v + (mx + 1) - s;
      end
    end
    return {o, u, 8'(v)};
  endfunction

  always @(posedge clk) begin
    if (!reset_n) model_on <= 1'b1;
    for (int i = 0; i < N; i++) mst[i] <= model_next(i, mst[i]);
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("cycle_d%0d t=%0t", i, $time),
              {val[i], ovf[i], unf[i], amax[i], azero[i]},
              {mst[i][7:0], mst[i][9], mst[i][8],
               (int'(mst[i][7:0]) == MXS[i]), (mst[i][7:0] == 8'd0)});
      end
    end
  end

  // Hand-computed expectation for instance i; pins both the DUT and the model
  task automatic lit(input string name, input int i, input int v, input bit o, input bit u);
    check({name, "_dut"}, {2'b00, val[i], ovf[i], unf[i]}, {2'b00, 8'(v), o, u});
    check({name, "_model"}, {2'b00, mst[i][7:0], mst[i][9], mst[i][8]}, {2'b00, 8'(v), o, u});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; up = 1'b1; step = 8'd0;
    load = 1'b0; load_value = 8'd0; clear = 1'b0;
    tick();
    lit("reset", 0, 0, 0, 0);

    // Idle after reset
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      lit("idle", 0, 0, 0, 0);
      check("idle_at_zero", {11'd0, azero[0]}, 12'd1);
    end

    // Legacy wrap
    enable = 1'b1; up = 1'b1; step = 8'd1;
    repeat (255) tick();
    lit("legacy_255", 0, 255, 0, 0);
    tick();
    lit("legacy_wrap", 0, 0, 1, 0);
    tick();
    lit("legacy_next", 0, 1, 0, 0);
    lit("mod10_after257", 1, 7, 0, 0);
    lit("sat_after257", 2, 200, 1, 0);

    // Down wrap from zero
    clear = 1'b1; tick(); clear = 1'b0;
    up = 1'b0; tick();
    lit("down_wrap", 0, 255, 0, 1);

    // Modulus and step (MAX_VALUE=9)
    enable = 1'b0; load = 1'b1; load_value = 8'd7; tick(); load = 1'b0;
    enable = 1'b1; up = 1'b1; step = 8'd4; tick();
    lit("mod_up_wrap", 1, 1, 1, 0);
    up = 1'b0; step = 8'd3; tick();
    lit("mod_down_wrap", 1, 8, 0, 1);
    step = 8'd2; tick();
    lit("mod_down", 1, 6, 0, 0);

    // Saturate (MAX_VALUE=200)
    enable = 1'b0; load = 1'b1; load_value = 8'd198; tick(); load = 1'b0;
    enable = 1'b1; up = 1'b1; step = 8'd5; tick();
    lit("sat_up", 2, 200, 1, 0);
    check("sat_at_max", {11'd0, amax[2]}, 12'd1);
    tick();
    lit("sat_up_again", 2, 200, 1, 0);
    up = 1'b0; step = 8'd250; tick();
    lit("sat_down_exact", 2, 0, 0, 0);
    tick();
    lit("sat_down_clamp", 2, 0, 0, 1);
    check("sat_at_zero", {11'd0, azero[2]}, 12'd1);

    // Priority
    clear = 1'b1; load = 1'b1; load_value = 8'd50; enable = 1'b1; up = 1'b1; step = 8'd1;
    tick();
    lit("prio_clear_d0", 0, 0, 0, 0);
    lit("prio_clear_d2", 2, 0, 0, 0);
    clear = 1'b0; tick();
    lit("prio_load", 0, 50, 0, 0);
    load_value = 8'd255; tick();
    lit("load_clamp", 3, 100, 0, 0);
    lit("load_full", 0, 255, 0, 0);

    // Reset mid-operation
    load = 1'b0; tick();
    lit("pre_reset_ovf", 0, 0, 1, 0);
    reset_n = 1'b0; load = 1'b1; load_value = 8'd50; tick();
    lit("mid_reset_d0", 0, 0, 0, 0);
    lit("mid_reset_d3", 3, 0, 0, 0);
    reset_n = 1'b1; enable = 1'b0; load_value = 8'd5; tick();
    load = 1'b0; enable = 1'b1; step = 8'd0; tick();
    lit("step0_d0", 0, 5, 0, 0);
    lit("step0_d1", 1, 5, 0, 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
